// File: rtl/pos_cache_reader.sv
// Streams the particle positions of the active cell out of the position cache:
// reads the count from address 0, then addresses 1..count through a 2-entry FIFO.
module pos_cache_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    out_rden,
    output logic [ADDR_WIDTH-1:0]   out_rd_addr,
    input  logic [3*DATA_WIDTH-1:0] in_particle_info,
    output logic [3*DATA_WIDTH-1:0] out_particle,
    output logic [ADDR_WIDTH-1:0]   out_particle_id,
    output logic                    out_valid,
    input  logic                    in_ready,
    output logic [ADDR_WIDTH-1:0]   out_particle_count,
    output logic                    busy,
    output logic                    done,
    output logic                    count_err,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ_NUM = 3'd1,
        S_WAIT_NUM = 3'd2,
        S_STREAM   = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM);

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]   count_q;
    logic [ADDR_WIDTH-1:0]   issued_q;
    logic                    inflight_q;
    logic [ADDR_WIDTH-1:0]   inflight_addr_q;

    logic [3*DATA_WIDTH-1:0] fifo_data [2];
    logic [ADDR_WIDTH-1:0]   fifo_id [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              occ;

    logic                    push;
    logic                    pop;
    logic                    issue;
    logic                    all_issued;
    logic                    drain_done;
    logic [2:0]              level;
    logic [1:0]              occ_after_pop;
    logic [ADDR_WIDTH-1:0]   raw_count;
    logic                    over;

    // Handshake: a particle transfers on a rising edge where out_valid && in_ready.
    // out_valid never depends on in_ready, and the head is held until taken.
    assign out_valid       = (occ != 2'd0);
    assign out_particle    = fifo_data[rd_ptr];
    assign out_particle_id = fifo_id[rd_ptr];
    assign pop             = out_valid && in_ready;
    assign push            = inflight_q;

    assign out_particle_count = count_q;
    assign dbg_state          = state;

    assign raw_count = in_particle_info[ADDR_WIDTH-1:0];
    assign over      = (raw_count > MAX_COUNT);

    // Slots committed after this cycle: buffered + arriving - leaving. A new read
    // is allowed only if its data will still find a free slot next cycle.
    assign level         = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign all_issued    = (issued_q == count_q);
    assign occ_after_pop = occ - {1'b0, pop};
    assign drain_done    = all_issued && !inflight_q && (occ_after_pop == 2'd0);
    assign issue         = (state == S_STREAM) && !all_issued && (level < 3'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        out_rden    = 1'b0;
        out_rd_addr = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_READ_NUM;
                end
            end
            S_READ_NUM: begin
                busy      = 1'b1;
                out_rden  = 1'b1;
                state_nxt = S_WAIT_NUM;
            end
            S_WAIT_NUM: begin
                busy      = 1'b1;
                state_nxt = (raw_count == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                busy = 1'b1;
                if (issue) begin
                    out_rden    = 1'b1;
                    out_rd_addr = issued_q + 1'b1;
                end
                if (drain_done) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Count latch, sticky error flag and read issue tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q         <= '0;
            count_err       <= 1'b0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                count_q   <= '0;
                count_err <= 1'b0;
                issued_q  <= '0;
            end
            if (state == S_WAIT_NUM) begin
                count_q <= over ? MAX_COUNT : raw_count;
                if (over) begin
                    count_err <= 1'b1;
                end
            end
            if (issue) begin
                issued_q <= issued_q + 1'b1;
            end
            // Only particle reads are tagged in flight; the count read is not.
            inflight_q      <= issue;
            inflight_addr_q <= out_rd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_id[i]   <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= in_particle_info;
                fifo_id[wr_ptr]   <= inflight_addr_q;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_pos_cache_reader.sv
// Bench for pos_cache_reader: a cache memory model, a table of stream scenarios,
// randomized runs and hand-written reset/latency sequences checked by a scoreboard.
module tb_pos_cache_reader;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int IW = AW + 3 * DW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              in_ready = 1'b0;
    logic              out_rden;
    logic [AW-1:0]     out_rd_addr;
    logic [3*DW-1:0]   in_particle_info;
    logic [3*DW-1:0]   out_particle;
    logic [AW-1:0]     out_particle_id;
    logic              out_valid;
    logic [AW-1:0]     out_particle_count;
    logic              busy;
    logic              done;
    logic              count_err;
    logic [2:0]        dbg_state;

    logic [3*DW-1:0]   mem [256];
    logic [3*DW-1:0]   cache_q = '0;
    logic [IW-1:0]     exp_q[$];
    logic [AW-1:0]     exp_rd_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e0 = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    int first_valid_off = 0;
    int last_valid_off = 0;
    int done_off = 0;
    bit hold_v = 1'b0;
    logic [IW-1:0] hold_item = '0;

    typedef struct {
        int cnt;
        int mode;       // 0: ready held 1, 1: ready toggles 1010..., 2: random ready
        int exp_count;
        bit exp_err;
        int repulse;    // cycle offset to re-pulse start, 0 = none
    } vec_t;

    vec_t vecs[10];

    pos_cache_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .PARTICLE_NUM(PN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .out_rden(out_rden),
        .out_rd_addr(out_rd_addr),
        .in_particle_info(in_particle_info),
        .out_particle(out_particle),
        .out_particle_id(out_particle_id),
        .out_valid(out_valid),
        .in_ready(in_ready),
        .out_particle_count(out_particle_count),
        .busy(busy),
        .done(done),
        .count_err(count_err),
        .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cache model: data for a read appears the cycle after out_rden
    always @(posedge clk) cache_q <= out_rden ? mem[out_rd_addr] : {3{32'hbad0_bad0}};
    assign in_particle_info = cache_q;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    // Scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            hold_v = 1'b0;
        end else begin
            if (out_rden) begin
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_extra actual addr=%0d expected no read", out_rd_addr);
                end else begin
                    check("rd_addr", out_rd_addr, exp_rd_q.pop_front());
                end
            end else begin
                check("rd_idle_addr", out_rd_addr, 0);
            end
            if (hold_v) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", {out_particle_id, out_particle}, hold_item);
            end
            hold_v = out_valid && !in_ready;
            hold_item = {out_particle_id, out_particle};
            if (out_valid) begin
                if (first_valid_off == 0) first_valid_off = cyc - e0 + 1;
                last_valid_off = cyc - e0 + 1;
            end
            if (out_valid && in_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL particle_extra actual id=%0d expected none", out_particle_id);
                end else begin
                    check("particle", {out_particle_id, out_particle}, exp_q.pop_front());
                end
                acc_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_off = cyc - e0 + 1;
            end
        end
    end

    // Reference model: fills the cache and queues the expected reads and particles
    task automatic load_cell(input int cnt);
        logic [3*DW-1:0] w;
        int n;
        n = (cnt > PN) ? PN : cnt;
        w = {$urandom, $urandom, $urandom};
        w[AW-1:0] = AW'(cnt);
        mem[0] = w;
        for (int i = 1; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
        exp_rd_q.push_back(AW'(0));
        for (int i = 1; i <= n; i++) begin
            exp_rd_q.push_back(AW'(i));
            exp_q.push_back({AW'(i), mem[i]});
        end
    endtask

    task automatic pulse_start();
        done_cnt = 0;
        acc_cnt = 0;
        first_valid_off = 0;
        last_valid_off = 0;
        done_off = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic run_stream(input int cnt, input int mode, input int exp_count,
                              input bit exp_err, input int repulse);
        load_cell(cnt);
        pulse_start();
        for (int k = 1; k <= 3000; k++) begin
            case (mode)
                0: in_ready = 1'b1;
                1: in_ready = k[0];
                default: in_ready = 1'($urandom_range(0, 1));
            endcase
            start = (k == repulse);
            if (k == 1) check("busy_after_start", busy, 1);
            @(posedge clk); #1;
            if (done_cnt != 0) break;
        end
        start = 1'b0;
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual no done expected done for count %0d", cnt);
        end
        in_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", done_cnt, 1);
        check("particles_left", exp_q.size(), 0);
        check("reads_left", exp_rd_q.size(), 0);
        check("particle_count", out_particle_count, exp_count);
        check("count_err", count_err, exp_err);
        check("busy_idle", busy, 0);
        check("valid_idle", out_valid, 0);
        if (exp_count == 0) check("no_valid_zero", first_valid_off, 0);
        exp_q.delete();
        exp_rd_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rden"}, out_rden, 0);
        check({tag, "_rd_addr"}, out_rd_addr, 0);
        check({tag, "_particle"}, out_particle, 0);
        check({tag, "_id"}, out_particle_id, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_count"}, out_particle_count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_count_err"}, count_err, 0);
    endtask

    initial begin
        int c;
        vecs[0] = '{cnt: 3,   mode: 0, exp_count: 3,   exp_err: 1'b0, repulse: 0};
        vecs[1] = '{cnt: 0,   mode: 0, exp_count: 0,   exp_err: 1'b0, repulse: 0};
        vecs[2] = '{cnt: 4,   mode: 1, exp_count: 4,   exp_err: 1'b0, repulse: 0};
        vecs[3] = '{cnt: 250, mode: 0, exp_count: 220, exp_err: 1'b1, repulse: 0};
        vecs[4] = '{cnt: 1,   mode: 2, exp_count: 1,   exp_err: 1'b0, repulse: 0};
        vecs[5] = '{cnt: 6,   mode: 0, exp_count: 6,   exp_err: 1'b0, repulse: 6};
        vecs[6] = '{cnt: 221, mode: 2, exp_count: 220, exp_err: 1'b1, repulse: 0};
        vecs[7] = '{cnt: 220, mode: 2, exp_count: 220, exp_err: 1'b0, repulse: 0};
        vecs[8] = '{cnt: 7,   mode: 1, exp_count: 7,   exp_err: 1'b0, repulse: 3};
        vecs[9] = '{cnt: 2,   mode: 2, exp_count: 2,   exp_err: 1'b0, repulse: 0};

        for (int i = 0; i < 256; i++) mem[i] = '0;
        #12;
        check_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            run_stream(vecs[i].cnt, vecs[i].mode, vecs[i].exp_count, vecs[i].exp_err,
                       vecs[i].repulse);
        end

        // Latency of a 3-particle cell; offset 1 is the cycle after start is sampled
        run_stream(3, 0, 3, 1'b0, 0);
        check("first_valid_off", first_valid_off, 5);
        check("last_valid_off", last_valid_off, 7);
        check("done_off", done_off, 8);

        // Randomized cells under random back-pressure
        for (int r = 0; r < 5; r++) begin
            c = $urandom_range(0, 255);
            run_stream(c, 2, (c > PN) ? PN : c, c > PN, 0);
        end

        // Reset after the 2nd accepted particle of a 5-particle cell
        load_cell(5);
        pulse_start();
        in_ready = 1'b1;
        for (int k = 0; k < 50 && acc_cnt < 2; k++) begin
            @(posedge clk); #1;
        end
        check("accepted_before_reset", acc_cnt, 2);
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        exp_rd_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("held_reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        run_stream(5, 0, 5, 1'b0, 0);
        check("after_reset_accepted", acc_cnt, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pos_cache_reader.md
POS_CACHE_READER -- requirements
Module: pos_cache_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one position component.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, position cache address width.
REQ-003 SHALL have parameter PARTICLE_NUM, default 220, maximum particles per cell.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to stream the active cell.
REQ-007 SHALL have port out_rden  output  1  read enable to position cache.
REQ-008 SHALL have port out_rd_addr  output  ADDR_WIDTH  read address to position cache.
REQ-009 SHALL have port in_particle_info  input  3*DATA_WIDTH  cache read data {posz,posy,posx}, valid 1 cycle after out_rden.
REQ-010 SHALL have port out_particle  output  3*DATA_WIDTH  streamed position.
REQ-011 SHALL have port out_particle_id  output  ADDR_WIDTH  cache address of out_particle (1..N).
REQ-012 SHALL have port out_valid  output  1  out_particle/out_particle_id valid.
REQ-013 SHALL have port in_ready  input  1  consumer accepts when out_valid && in_ready.
REQ-014 SHALL have port out_particle_count  output  ADDR_WIDTH  particle count latched from address 0 (after clamp).
REQ-015 SHALL have port busy  output  1  high from start acceptance until done.
REQ-016 SHALL have port done  output  1  one-cycle pulse after last particle accepted.
REQ-017 SHALL have port count_err  output  1  sticky flag: address-0 count exceeded PARTICLE_NUM.

Function
REQ-018 SHALL implement FSM IDLE -> READ_NUM -> WAIT_NUM -> STREAM -> DONE -> IDLE.
REQ-019 IDLE: start=1 SHALL go to READ_NUM and set busy; start while busy SHALL be ignored.
REQ-020 READ_NUM: out_rden=1, out_rd_addr=0 for exactly one cycle; next WAIT_NUM.
REQ-021 WAIT_NUM: latch count = in_particle_info[ADDR_WIDTH-1:0]; count>PARTICLE_NUM SHALL clamp to PARTICLE_NUM and set count_err; count=0 SHALL go directly to DONE, else STREAM.
REQ-022 STREAM SHALL issue reads at addresses 1,2,...,count in order, each one cycle with out_rden=1.
REQ-023 Returned data SHALL be written, with its address, into a 2-entry FIFO the cycle after the read.
REQ-024 A read SHALL be issued only when (FIFO occupancy + reads in flight - pop this cycle) < 2; no FIFO overflow under any in_ready pattern.
REQ-025 out_valid SHALL equal FIFO non-empty; out_particle/out_particle_id SHALL be the FIFO head and stay stable while out_valid && !in_ready.
REQ-026 Pop SHALL occur on out_valid && in_ready; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-027 With in_ready held 1, sustained throughput SHALL be one particle per cycle.
REQ-028 Latency: start sampled at edge E0 -> first out_valid at E0+5 cycles (READ_NUM, WAIT_NUM, first read, data return, FIFO output).
REQ-029 STREAM -> DONE SHALL occur when all count reads issued, none in flight, FIFO empty.
REQ-030 DONE SHALL pulse done=1 for one cycle, clear busy, return to IDLE; out_particle_count SHALL hold until next start.
REQ-031 out_rden=0 and out_rd_addr=0 in all cycles with no read issued.
REQ-032 count_err SHALL clear only on reset or on next accepted start.

Reset
REQ-033 rst=0 SHALL asynchronously force IDLE, empty FIFO, no reads in flight, and all outputs 0 (out_rden, out_rd_addr, out_particle, out_particle_id, out_valid, out_particle_count, busy, done, count_err).
REQ-034 Reset asserted mid-stream SHALL abort without emitting remaining particles; after release the block SHALL accept a new start normally.

Verification
REQ-035 Count=3, in_ready=1: start -> reads addr 0,1,2,3; out_particle_id 1,2,3 on consecutive cycles from E0+5; done at E0+8.
REQ-036 Count=0: start -> single read of addr 0, no out_valid, done pulse, out_particle_count=0.
REQ-037 Count=4, in_ready toggling 1010...: all 4 particles delivered in order, no loss/duplication, data stable while stalled.
REQ-038 Count=250 with PARTICLE_NUM=220: exactly 220 particles streamed, count_err=1, out_particle_count=220.
REQ-039 start re-pulsed during STREAM: ignored, single stream completes, one done pulse.
REQ-040 rst=0 after 2nd particle of count=5: all outputs 0 immediately; new start after release streams ids 1..5.
